alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Central arming/disarming FSM for the anti-intrusion system; sits between the keypad decoder and sensor inputs on one side and the LCD/7-seg/buzzer/alarm drivers on the other.
- Collects keypad digits, checks the access code on enter, and runs timed exit delay, entry delay, alarm escalation and lockout sequences.
- Exposes state and remaining-time outputs for the display blocks.

Parameters:
- TICK_DIV, 50000000, clk cycles per timer tick (1 s at 50 MHz).
- CODE_LEN, 4, digits in the access code (1..4).
- CODE, 16'h1234, access code as packed BCD digits, first digit in MSBs.
- EXIT_TICKS, 30, exit delay in ticks.
- ENTRY_TICKS, 15, entry delay in ticks.
- ESC_TICKS, 60, ticks in ALARM before alarm_out2 asserts.
- MAX_FAILS, 3, consecutive wrong codes that trigger the fail action.
- LOCK_TICKS, 60, lockout duration in ticks.

Ports:
- clk  in  1  system clock.
- rst2  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  4  0..9 = digit; 4'hA = clear entry; other values ignored.
- enter  in  1  one-cycle pulse, debounced upstream.
- sensor  in  3  [0] = door (delayed zone); [2:1] = window/interior (instant zones); level-sensitive, pre-synchronised.
- state  out  3  0 DISARMED, 1 EXIT_DLY, 2 ARMED, 3 ENTRY_DLY, 4 ALARM, 5 LOCKOUT.
- digits  out  3  digits currently entered (0..CODE_LEN).
- time_left  out  8  remaining ticks of the active timer; 0 when no timer runs.
- buzzer_out  out  1  beeper drive.
- alarm_out1  out  1  primary siren.
- alarm_out2  out  1  escalation output.

Behaviour:
- Reset (rst2 = 0, asynchronous): state = DISARMED; all counters, the entry register and the fail count clear; all outputs 0.
- Prescaler counts 0..TICK_DIV-1. tick is a one-cycle pulse at wrap. Timers load on state entry and decrement on tick. A timer expires in the cycle where tick occurs with value 1.
- Key entry:
  - Digit: shifts into a 16-bit entry register (4 bits per digit); digits increments, saturating at CODE_LEN. Further digits are ignored.
  - 4'hA: clears the entry register and digits.
  - Keys are ignored in LOCKOUT.
- Enter:
  - match = (digits == CODE_LEN) && (entry == CODE[4*CODE_LEN-1:0]).
  - The entry register and digits clear on the following cycle regardless of match.
  - enter in LOCKOUT is ignored.
- Match: fail count clears. DISARMED -> EXIT_DLY. EXIT_DLY, ARMED, ENTRY_DLY, ALARM -> DISARMED.
- Mismatch: fail count increments. On reaching MAX_FAILS, fail count clears and:
  - DISARMED -> LOCKOUT.
  - EXIT_DLY, ARMED, ENTRY_DLY -> ALARM.
  - ALARM stays in ALARM.
- Timed transitions:
  - EXIT_DLY: expiry -> ARMED. Sensors are ignored during EXIT_DLY.
  - ARMED: sensor[2:1] != 0 -> ALARM; else sensor[0] = 1 -> ENTRY_DLY.
  - ENTRY_DLY: expiry or sensor[2:1] != 0 -> ALARM.
  - LOCKOUT: expiry -> DISARMED.
  - ALARM: latched until a match; sensors are ignored.
- Priority in one cycle: match/mismatch action > timer expiry > sensor events. A key_valid coincident with enter is discarded.
- Outputs are registered and change one cycle after the state change:
  - buzzer_out toggles each tick in EXIT_DLY and ENTRY_DLY; steady 1 in ALARM and LOCKOUT; 0 otherwise.
  - alarm_out1 = 1 in ALARM.
  - alarm_out2 = 1 once ESC_TICKS ticks have elapsed in ALARM; cleared on leaving ALARM.
  - time_left shows the running timer in EXIT_DLY, ENTRY_DLY and LOCKOUT, and the escalation countdown in ALARM (0 after escalation).
- Prescaler phase is not reset on state changes; the first tick in a state may therefore arrive early (≤1 tick of jitter, accepted).

Test Plan:
Bench parameters: TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=2, ESC_TICKS=2, LOCK_TICKS=3, MAX_FAILS=3, CODE=16'h1234.
- Keys 1,2,3,4 then enter in DISARMED -> state=1, time_left=3. After 12 cycles, state=2; buzzer_out toggled at each tick in between.
- In ARMED, set sensor=3'b001 -> state=3. After 8 cycles, state=4, alarm_out1=1. After 8 more cycles, alarm_out2=1. Then 1,2,3,4 + enter -> state=0, all alarm outputs 0.
- In ARMED, set sensor=3'b100 -> state=4 on the next cycle with no entry delay. Sensor=3'b101 gives the same result (instant zone wins).
- In DISARMED, three entries 9,9,9,9 + enter -> state=5 and buzzer_out=1. Keys are ignored; after 12 cycles, state=0.
- Keys 1,2,3,4,5 + enter -> digits shows 4 before enter and the code matches (5th digit ignored). Keys 1,2,A,3,4 + enter -> digits=2 and the code mismatches.
- Assert rst2=0 mid-ENTRY_DLY, asynchronously with no clock edge -> state=0, time_left=0, all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// Keypad/sensor inputs and display/driver outputs of the alarm sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface alarm_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       enter;
    logic [2:0] sensor;
    logic [2:0] state;
    logic [2:0] digits;
    logic [7:0] time_left;
    logic       buzzer_out;
    logic       alarm_out1;
    logic       alarm_out2;

    modport slave (
        input  key_valid, key_code, enter, sensor,
        output state, digits, time_left, buzzer_out, alarm_out1, alarm_out2
    );

    modport master (
        output key_valid, key_code, enter, sensor,
        input  state, digits, time_left, buzzer_out, alarm_out1, alarm_out2
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Arming/disarming sequencer: code entry, exit/entry delays, alarm escalation
// and lockout, with a shared tick prescaler driving one countdown timer.
module alarm_sequencer #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned CODE_LEN    = 4,
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int unsigned EXIT_TICKS  = 30,
    parameter int unsigned ENTRY_TICKS = 15,
    parameter int unsigned ESC_TICKS   = 60,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_TICKS  = 60
) (
    input logic          clk,
    input logic          rst2,
    alarm_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_EXIT_DLY  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ENTRY_DLY = 3'd3,
        ST_ALARM     = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_t;

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW       = 4 * CODE_LEN;
    localparam logic [15:0] W_MASK   = 16'hFFFF >> (16 - CW);
    localparam logic [15:0] CODE_REF = CODE & W_MASK;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [7:0]    r_timer;
    logic [7:0]    w_timer_load;
    logic          w_expire;
    logic [15:0]   r_entry;
    logic [2:0]    r_digits;
    logic [7:0]    r_fails;
    logic          w_enter_ok;
    logic          w_match;
    logic          w_mismatch;
    logic          w_fail_act;
    logic          w_instant;
    logic          r_buzz;
    logic          r_alarm1;
    logic          r_alarm2;

    // Free-running prescaler; its phase is deliberately independent of the FSM.
    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_enter_ok = bus.enter && (r_state != ST_LOCKOUT);
    assign w_match    = w_enter_ok && (r_digits == 3'(CODE_LEN)) && (r_entry == CODE_REF);
    assign w_mismatch = w_enter_ok && !w_match;
    assign w_fail_act = w_mismatch && (r_fails == 8'(MAX_FAILS - 1));
    assign w_expire   = w_tick && (r_timer == 8'd1);
    assign w_instant  = |bus.sensor[2:1];

    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_next;
        end
    end

    // Code verdicts outrank timer expiry, which outranks sensor events.
    always_comb begin
        w_next       = r_state;
        w_timer_load = '0;
        if (w_match) begin
            w_next = (r_state == ST_DISARMED) ? ST_EXIT_DLY : ST_DISARMED;
        end else if (w_fail_act) begin
            case (r_state)
                ST_DISARMED:                        w_next = ST_LOCKOUT;
                ST_EXIT_DLY, ST_ARMED, ST_ENTRY_DLY: w_next = ST_ALARM;
                default:                            w_next = r_state;
            endcase
        end else begin
            case (r_state)
                ST_EXIT_DLY: begin
                    if (w_expire) w_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_instant)          w_next = ST_ALARM;
                    else if (bus.sensor[0]) w_next = ST_ENTRY_DLY;
                end
                ST_ENTRY_DLY: begin
                    if (w_expire || w_instant) w_next = ST_ALARM;
                end
                ST_LOCKOUT: begin
                    if (w_expire) w_next = ST_DISARMED;
                end
                default: w_next = r_state;
            endcase
        end
        case (w_next)
            ST_EXIT_DLY:  w_timer_load = 8'(EXIT_TICKS);
            ST_ENTRY_DLY: w_timer_load = 8'(ENTRY_TICKS);
            ST_ALARM:     w_timer_load = 8'(ESC_TICKS);
            ST_LOCKOUT:   w_timer_load = 8'(LOCK_TICKS);
            default:      w_timer_load = '0;
        endcase
    end

    // In ALARM the same timer is the escalation countdown and parks at zero.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= w_timer_load;
        end else if (w_tick && (r_timer != 8'd0)) begin
            r_timer <= r_timer - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_fails <= '0;
        end else if (w_match) begin
            r_fails <= '0;
        end else if (w_mismatch) begin
            r_fails <= w_fail_act ? 8'd0 : (r_fails + 8'd1);
        end
    end

    // A key strobe coinciding with a valid enter is lost to the clear.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_entry  <= '0;
            r_digits <= '0;
        end else if (w_enter_ok) begin
            r_entry  <= '0;
            r_digits <= '0;
        end else if (bus.key_valid && (r_state != ST_LOCKOUT)) begin
            if (bus.key_code <= 4'd9) begin
                if (r_digits < 3'(CODE_LEN)) begin
                    r_entry  <= {r_entry[11:0], bus.key_code};
                    r_digits <= r_digits + 3'd1;
                end
            end else if (bus.key_code == 4'hA) begin
                r_entry  <= '0;
                r_digits <= '0;
            end
        end
    end

    // Driver outputs follow the current state, so they trail a transition by a cycle.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            r_buzz   <= 1'b0;
            r_alarm1 <= 1'b0;
            r_alarm2 <= 1'b0;
        end else begin
            case (r_state)
                ST_EXIT_DLY, ST_ENTRY_DLY: r_buzz <= r_buzz ^ w_tick;
                ST_ALARM, ST_LOCKOUT:      r_buzz <= 1'b1;
                default:                   r_buzz <= 1'b0;
            endcase
            r_alarm1 <= (r_state == ST_ALARM);
            r_alarm2 <= (r_state == ST_ALARM) && (r_alarm2 || w_expire);
        end
    end

    assign bus.state      = r_state;
    assign bus.digits     = r_digits;
    assign bus.time_left  = r_timer;
    assign bus.buzzer_out = r_buzz;
    assign bus.alarm_out1 = r_alarm1;
    assign bus.alarm_out2 = r_alarm2;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomised and directed stimulus for alarm_sequencer, checked every cycle
// against a behavioural model of the arming rules.
module tb_alarm_sequencer;

    localparam int TDIV    = 4;
    localparam int CLEN    = 4;
    localparam int EXIT_T  = 3;
    localparam int ENTRY_T = 2;
    localparam int ESC_T   = 2;
    localparam int MAXF    = 3;
    localparam int LOCK_T  = 3;
    localparam logic [15:0] CODE = 16'h1234;

    logic clk  = 1'b0;
    logic rst2 = 1'b0;

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .TICK_DIV(TDIV), .CODE_LEN(CLEN), .CODE(CODE), .EXIT_TICKS(EXIT_T),
        .ENTRY_TICKS(ENTRY_T), .ESC_TICKS(ESC_T), .MAX_FAILS(MAXF), .LOCK_TICKS(LOCK_T)
    ) dut (
        .clk(clk),
        .rst2(rst2),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 disarmed,1 exit,2 armed,3 entry,4 alarm,5 lockout
    int   m_cyc;
    int   m_state;
    int   m_rem;
    int   m_fails;
    int   m_q[$];
    bit   m_buzz, m_a1, m_a2;
    logic [2:0] cur_sens;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int code_digit(input int i);
        logic [15:0] c;
        c = CODE >> (4 * (CLEN - 1 - i));
        return int'(c & 16'hF);
    endfunction

    function automatic int delay_of(input int s);
        case (s)
            1:       return EXIT_T;
            3:       return ENTRY_T;
            4:       return ESC_T;
            5:       return LOCK_T;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_state = 0; m_rem = 0; m_fails = 0;
        m_q.delete();
        m_buzz = 0; m_a1 = 0; m_a2 = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit en, input logic [2:0] s);
        bit tick, ok, decided, expire;
        int prev, nxt;
        tick = ((m_cyc % TDIV) == TDIV - 1);
        m_cyc++;
        prev = m_state;
        nxt = prev;
        decided = 0;
        expire = tick && (m_rem == 1);
        if (prev == 1 || prev == 3) m_buzz = m_buzz ^ tick;
        else                        m_buzz = (prev == 4 || prev == 5);
        m_a2 = (prev == 4) && (m_a2 || expire);
        m_a1 = (prev == 4);
        if (en && prev != 5) begin
            ok = (m_q.size() == CLEN);
            if (ok) for (int i = 0; i < CLEN; i++) if (m_q[i] != code_digit(i)) ok = 0;
            m_q.delete();
            if (ok) begin
                m_fails = 0;
                decided = 1;
                nxt = (prev == 0) ? 1 : 0;
            end else begin
                m_fails++;
                if (m_fails == MAXF) begin
                    m_fails = 0;
                    decided = 1;
                    nxt = (prev == 0) ? 5 : 4;
                end
            end
        end else if (kv && prev != 5) begin
            if (kc <= 9) begin
                if (m_q.size() < CLEN) m_q.push_back(kc);
            end else if (kc == 10) begin
                m_q.delete();
            end
        end
        if (!decided) begin
            case (prev)
                1: if (expire) nxt = 2;
                2: if (s[2:1] != 0) nxt = 4; else if (s[0]) nxt = 3;
                3: if (expire || s[2:1] != 0) nxt = 4;
                5: if (expire) nxt = 0;
                default: ;
            endcase
        end
        if (nxt != prev)            m_rem = delay_of(nxt);
        else if (tick && m_rem > 0) m_rem--;
        m_state = nxt;
    endtask

    task automatic cycle(input bit kv, input int kc, input bit en);
        bus.key_valid = kv;
        bus.key_code  = 4'(kc);
        bus.enter     = en;
        bus.sensor    = cur_sens;
        @(posedge clk);
        #1;
        model_step(kv, kc, en, cur_sens);
        chk("state",     bus.state,      m_state);
        chk("digits",    bus.digits,     m_q.size());
        chk("time_left", bus.time_left,  m_rem);
        chk("buzzer",    bus.buzzer_out, m_buzz);
        chk("alarm1",    bus.alarm_out1, m_a1);
        chk("alarm2",    bus.alarm_out2, m_a2);
        bus.key_valid = 1'b0;
        bus.enter     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic key(input int k);
        cycle(1, k, 0);
    endtask

    task automatic good_code();
        key(1); key(2); key(3); key(4);
        cycle(0, 0, 1);
    endtask

    task automatic bad_code();
        key(9); key(9); key(9); key(9);
        cycle(0, 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"},  bus.state,      0);
        chk({tag, "_digits"}, bus.digits,     0);
        chk({tag, "_time"},   bus.time_left,  0);
        chk({tag, "_buzz"},   bus.buzzer_out, 0);
        chk({tag, "_a1"},     bus.alarm_out1, 0);
        chk({tag, "_a2"},     bus.alarm_out2, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.enter     = 1'b0;
        bus.sensor    = 3'b000;
        cur_sens      = 3'b000;
        model_reset();
        #12;
        check_all_zero("reset");
        rst2 = 1'b1;

        // arm and let the exit delay run out
        good_code();
        chk("exit_entered", bus.state, 1);
        idle(13);
        chk("armed_reached", bus.state, 2);

        // door: entry delay, alarm, escalation, then disarm
        cur_sens = 3'b001;
        idle(1);
        chk("entry_dly", bus.state, 3);
        idle(8);
        chk("alarm_after_entry", bus.state, 4);
        cur_sens = 3'b000;
        idle(9);
        chk("escalated", bus.alarm_out2, 1);
        good_code();
        idle(2);
        chk("disarmed_a1", bus.alarm_out1, 0);

        // instant zones skip the entry delay
        good_code();
        idle(13);
        cur_sens = 3'b100;
        idle(1);
        chk("instant_alarm", bus.state, 4);
        cur_sens = 3'b000;
        good_code();
        good_code();
        idle(13);
        cur_sens = 3'b101;
        idle(1);
        chk("instant_wins", bus.state, 4);
        cur_sens = 3'b000;
        good_code();

        // three wrong codes lock the keypad out
        bad_code(); bad_code(); bad_code();
        chk("lockout", bus.state, 5);
        good_code();
        idle(10);
        chk("lockout_over", bus.state, 0);

        // digit saturation and clear key
        key(1); key(2); key(3); key(4); key(5);
        chk("digits_sat", bus.digits, 4);
        cycle(0, 0, 1);
        chk("sat_match", bus.state, 1);
        good_code();
        key(1); key(2); key(10); key(3); key(4);
        chk("digits_clr", bus.digits, 2);
        cycle(0, 0, 1);
        chk("clr_mismatch", bus.state, 0);

        // asynchronous reset in the middle of the entry delay
        good_code();
        idle(13);
        cur_sens = 3'b001;
        idle(1);
        cur_sens = 3'b000;
        rst2 = 1'b0;
        #2;
        check_all_zero("async_rst");
        model_reset();
        #2;
        rst2 = 1'b1;

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: good_code();
                2: begin
                    for (int d = 0; d < 4; d++) key($urandom_range(0, 9));
                    cycle(0, 0, 1);
                end
                3: key($urandom_range(0, 15));
                4: cycle($urandom_range(0, 1), $urandom_range(0, 15), 1);
                5: begin
                    cur_sens = 3'($urandom_range(0, 7));
                    idle($urandom_range(1, 6));
                    cur_sens = 3'b000;
                end
                default: begin
                    n = $urandom_range(1, 8);
                    idle(n);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
